rect_fill: RTL
==============

# rect_fill

AXI4 write master that fills a rectangle of the XGA (1024x768, 16 bpp) frame buffer with a solid colour. It sits upstream of the display read path, writing the same DDR frame buffer that the display controller scans out. Software drives it through GPIO: a base address, rectangle geometry and colour, a START edge, then it polls BUSY/DONE. It shares the display's ACLK domain and fixed AXI read-side conventions (INCR bursts, 4-byte beats, at most 16 beats).

## Interface
Parameters:
- C_M_AXI_ADDR_WIDTH, 32, AXI address width
- C_M_AXI_DATA_WIDTH, 32, AXI data width; only 32 is supported

Ports:
- ACLK  in  1  system clock
- ARST  in  1  reset, asynchronous, active-high
- M_AXI_AWADDR  out  32  burst start address
- M_AXI_AWLEN  out  8  beats-1 (0..15)
- M_AXI_AWSIZE  out  3  constant 2 (4 bytes)
- M_AXI_AWBURST  out  2  constant 2'b01 (INCR)
- M_AXI_AWCACHE  out  4  constant 4'b0010
- M_AXI_AWVALID / M_AXI_AWREADY  out/in  1  AW handshake
- M_AXI_WDATA  out  32  {COLOR, COLOR}
- M_AXI_WSTRB  out  4  constant 4'hF
- M_AXI_WLAST  out  1  last beat of burst
- M_AXI_WVALID / M_AXI_WREADY  out/in  1  W handshake
- M_AXI_BRESP  in  2  write response
- M_AXI_BVALID / M_AXI_BREADY  in/out  1  B handshake
- FILLBASE  in  32  frame buffer base; bits [11:0] ignored (treated as 0)
- FILLX, FILLY  in  10 each  top-left pixel; FILLX[0] ignored
- FILLW  in  11  width in pixels, 0..1024; FILLW[0] ignored
- FILLH  in  10  height in lines
- COLOR  in  16  pixel value
- START  in  1  GPIO level; a rising edge starts a fill
- BUSY  out  1  fill in progress
- DONE  out  1  one-cycle pulse at completion
- FILLERR  out  1  sticky error flag (see Configuration)

## Operation
- START is registered; a rising edge (prev 0, now 1) while IDLE latches all FILL*/COLOR inputs. Edges seen while BUSY are ignored and are not queued.
- Clipping at latch: xw = FILLX[9:1]; ww = FILLW[10:1]; if xw+ww > 512, ww = 512-xw. If FILLY >= 768, rows = 0; else rows = min(FILLH, 768-FILLY).
- If ww = 0 or rows = 0: no AXI traffic; DONE is pulsed on the next cycle.
- Row address = FILLBASE[31:12]<<12 + (row<<11) + (xw<<2), computed modulo 2^32. Bursts never cross a 2048-byte row, so they never cross 4 KB.
- Per row, the remaining word count rem starts at ww. Each burst is min(16, rem) beats. The address advances by beats*4. rem reaches 0 → next row.
- FSM:
  - IDLE: on START edge → ADDR, or → FIN if the clipped size is 0.
  - ADDR: AWVALID=1 until AWREADY → DATA.
  - DATA: WVALID=1 with a beat counter; WLAST on the final beat. Handshake on the last beat → RESP.
  - RESP: BREADY=1 until BVALID → ADDR if words remain, else → FIN.
  - FIN: DONE=1 for one cycle → IDLE.
- Only one outstanding burst. W never starts before its AW handshake.
- BUSY = (state != IDLE).

## Timing
- Reset values: AWVALID, WVALID, WLAST, BREADY, BUSY, DONE, FILLERR = 0; AWADDR = 0; AWLEN = 0; state = IDLE.
- ARST asserted mid-burst drops every valid/ready immediately and abandons the fill. No resume after release.
- START edge at cycle n → BUSY=1 at n+1 → AWVALID=1 at n+2.
- AWADDR and AWLEN are stable while AWVALID=1. WDATA is stable for the whole fill.
- The first WVALID comes in the cycle after the AW handshake.
- BVALID at cycle m during the last burst → DONE=1 at m+1 and BUSY=0 at m+2.
- Zero-size fill: START edge at n → DONE=1 at n+2 and BUSY=1 only at n+1.

## Configuration
- RECT_FILL_RESP_CHECK_EN defined:
  - Any BRESP != 2'b00 sets FILLERR, abandons the remaining bursts and goes to FIN (DONE still pulses).
  - FILLERR clears on the next accepted START edge or on ARST.
- Not defined: FILLERR is tied to 0 and BRESP is ignored.

## Test plan
- FILLBASE=0x1000_0000, X=0, Y=0, W=32, H=1, COLOR=0xF00 → exactly one burst: AWADDR=0x1000_0000, AWLEN=15, 16 beats of WDATA=0x0F000F00, then DONE.
- X=10, Y=2, W=40, H=2 → per row 20 words as bursts 16+4. AWADDR sequence 0x...1014, 0x...1054, 0x...1814, 0x...1854; AWLEN 15, 3, 15, 3.
- X=1000, W=100, Y=767, H=5 → clipped to 12 words × 1 row: a single burst with AWLEN=11 at base+767*2048+2000.
- W=0 → no AWVALID; DONE one cycle; BUSY high for exactly 1 cycle.
- Random AWREADY/WREADY/BVALID stalls and a START toggle while BUSY → no extra fill; valids held until handshake.
- With RECT_FILL_RESP_CHECK_EN, BRESP=2'b10 on the first of 4 bursts → FILLERR=1, no further AW, DONE pulses. Without the macro → all 4 bursts complete and FILLERR stays 0.

Source files
------------

// File: rtl/rect_fill_if.sv
// rect_fill_if: AXI4 write-channel bundle (AW, W, B) between rect_fill and the frame-buffer port.
interface rect_fill_if;
    logic [31:0] awaddr;
    logic [7:0]  awlen;
    logic [2:0]  awsize;
    logic [1:0]  awburst;
    logic [3:0]  awcache;
    logic        awvalid;
    logic        awready;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wlast;
    logic        wvalid;
    logic        wready;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready;

    modport master (
        output awaddr, awlen, awsize, awburst, awcache, awvalid,
        output wdata, wstrb, wlast, wvalid, bready,
        input  awready, wready, bresp, bvalid
    );

    modport slave (
        input  awaddr, awlen, awsize, awburst, awcache, awvalid,
        input  wdata, wstrb, wlast, wvalid, bready,
        output awready, wready, bresp, bvalid
    );
endinterface

// File: rtl/rect_fill.sv
// rect_fill: AXI4 write master painting a solid-colour rectangle into the 1024x768x16bpp frame buffer.
// Optional macro RECT_FILL_RESP_CHECK_EN: a non-OKAY BRESP aborts the fill and sets sticky FILLERR.
module rect_fill #(
    parameter int C_M_AXI_ADDR_WIDTH = 32,
    parameter int C_M_AXI_DATA_WIDTH = 32
) (
    input  logic        ACLK,
    input  logic        ARST,
    rect_fill_if.master m_axi,
    input  logic [31:0] FILLBASE,
    input  logic [9:0]  FILLX,
    input  logic [9:0]  FILLY,
    input  logic [10:0] FILLW,
    input  logic [9:0]  FILLH,
    input  logic [15:0] COLOR,
    input  logic        START,
    output logic        BUSY,
    output logic        DONE,
    output logic        FILLERR
);
    localparam int AW = C_M_AXI_ADDR_WIDTH;

    typedef enum logic [2:0] {
        S_IDLE, S_SETUP, S_ADDR, S_DATA, S_RESP, S_FIN
    } state_t;

    state_t      state_reg;
    logic        start_reg;
    logic [AW-1:0] row_addr_reg;
    logic [AW-1:0] awaddr_reg;
    logic [9:0]  ww_reg;
    logic [9:0]  rows_reg;
    logic [9:0]  rem_reg;
    logic [3:0]  beat_reg;
    logic [15:0] color_reg;
    logic [7:0]  awlen_reg;
    logic        awvalid_reg;
    logic        wvalid_reg;
    logic        wlast_reg;
    logic        bready_reg;
    logic        busy_reg;
    logic        done_reg;

    logic        start_edge;
    logic [8:0]  xw;
    logic [9:0]  ww_raw;
    logic [9:0]  ww_clip;
    logic [10:0] x_end;
    logic [9:0]  rows_avail;
    logic [9:0]  rows_clip;
    logic [AW-1:0] row0_addr;
    logic [4:0]  beats;
    logic [AW-1:0] step_bytes;
    logic        resp_err;
    logic        unused_bits;

    // Geometry is clipped once, at the START edge, against the 512-word row and 768 lines.
    assign start_edge = START && !start_reg;
    assign xw         = FILLX[9:1];
    assign ww_raw     = FILLW[10:1];
    assign x_end      = {2'b00, xw} + {1'b0, ww_raw};
    assign ww_clip    = (x_end > 11'd512) ? (10'd512 - {1'b0, xw}) : ww_raw;
    assign rows_avail = 10'd768 - FILLY;
    assign rows_clip  = (FILLY >= 10'd768) ? 10'd0 :
                        ((FILLH < rows_avail) ? FILLH : rows_avail);
    assign row0_addr  = {FILLBASE[31:12], 12'h000} + {11'd0, FILLY, 11'd0} + {21'd0, xw, 2'b00};
    assign beats      = {1'b0, awlen_reg[3:0]} + 5'd1;
    assign step_bytes = {25'd0, beats, 2'b00};

`ifdef RECT_FILL_RESP_CHECK_EN
    logic fillerr_reg;
    assign resp_err    = (m_axi.bresp != 2'b00);
    assign FILLERR     = fillerr_reg;
    assign unused_bits = ^{FILLBASE[11:0], FILLX[0], FILLW[0]};
`else
    assign resp_err    = 1'b0;
    assign FILLERR     = 1'b0;
    assign unused_bits = ^{FILLBASE[11:0], FILLX[0], FILLW[0], m_axi.bresp};
`endif

    function automatic logic [7:0] len_for(input logic [9:0] words);
        return (words >= 10'd16) ? 8'd15 : {4'd0, words[3:0] - 4'd1};
    endfunction

    always_ff @(posedge ACLK or posedge ARST) begin
        if (ARST) begin
            state_reg    <= S_IDLE;
            start_reg    <= 1'b0;
            row_addr_reg <= '0;
            awaddr_reg   <= '0;
            ww_reg       <= '0;
            rows_reg     <= '0;
            rem_reg      <= '0;
            beat_reg     <= '0;
            color_reg    <= '0;
            awlen_reg    <= '0;
            awvalid_reg  <= 1'b0;
            wvalid_reg   <= 1'b0;
            wlast_reg    <= 1'b0;
            bready_reg   <= 1'b0;
            busy_reg     <= 1'b0;
            done_reg     <= 1'b0;
`ifdef RECT_FILL_RESP_CHECK_EN
            fillerr_reg  <= 1'b0;
`endif
        end else begin
            start_reg <= START;
            case (state_reg)
                S_IDLE: if (start_edge) begin
                    ww_reg       <= ww_clip;
                    rows_reg     <= rows_clip;
                    row_addr_reg <= row0_addr;
                    color_reg    <= COLOR;
                    busy_reg     <= 1'b1;
                    state_reg    <= S_SETUP;
`ifdef RECT_FILL_RESP_CHECK_EN
                    fillerr_reg  <= 1'b0;
`endif
                end
                S_SETUP: begin
                    if (ww_reg == 10'd0 || rows_reg == 10'd0) begin
                        done_reg  <= 1'b1;
                        busy_reg  <= 1'b0;
                        state_reg <= S_FIN;
                    end else begin
                        awaddr_reg  <= row_addr_reg;
                        awlen_reg   <= len_for(ww_reg);
                        rem_reg     <= ww_reg;
                        awvalid_reg <= 1'b1;
                        state_reg   <= S_ADDR;
                    end
                end
                S_ADDR: if (m_axi.awready) begin
                    awvalid_reg <= 1'b0;
                    rem_reg     <= rem_reg - {5'd0, beats};
                    beat_reg    <= 4'd0;
                    wvalid_reg  <= 1'b1;
                    wlast_reg   <= (awlen_reg[3:0] == 4'd0);
                    state_reg   <= S_DATA;
                end
                S_DATA: if (m_axi.wready) begin
                    if (wlast_reg) begin
                        wvalid_reg <= 1'b0;
                        wlast_reg  <= 1'b0;
                        bready_reg <= 1'b1;
                        state_reg  <= S_RESP;
                    end else begin
                        beat_reg  <= beat_reg + 4'd1;
                        wlast_reg <= ((beat_reg + 4'd1) == awlen_reg[3:0]);
                    end
                end
                S_RESP: if (m_axi.bvalid) begin
                    bready_reg <= 1'b0;
                    if (resp_err || (rem_reg == 10'd0 && rows_reg == 10'd1)) begin
`ifdef RECT_FILL_RESP_CHECK_EN
                        if (resp_err)
                            fillerr_reg <= 1'b1;
`endif
                        done_reg  <= 1'b1;
                        state_reg <= S_FIN;
                    end else if (rem_reg != 10'd0) begin
                        awaddr_reg  <= awaddr_reg + step_bytes;
                        awlen_reg   <= len_for(rem_reg);
                        awvalid_reg <= 1'b1;
                        state_reg   <= S_ADDR;
                    end else begin
                        // Row finished: restart at the same column one 2 KB line down.
                        row_addr_reg <= row_addr_reg + 32'd2048;
                        awaddr_reg   <= row_addr_reg + 32'd2048;
                        awlen_reg    <= len_for(ww_reg);
                        rem_reg      <= ww_reg;
                        rows_reg     <= rows_reg - 10'd1;
                        awvalid_reg  <= 1'b1;
                        state_reg    <= S_ADDR;
                    end
                end
                S_FIN: begin
                    done_reg  <= 1'b0;
                    busy_reg  <= 1'b0;
                    state_reg <= S_IDLE;
                end
                default: state_reg <= S_IDLE;
            endcase
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < C_M_AXI_DATA_WIDTH / 16; gi++) begin : g_wdata
            assign m_axi.wdata[gi*16 +: 16] = color_reg;
        end
    endgenerate

    assign m_axi.awaddr  = awaddr_reg;
    assign m_axi.awlen   = awlen_reg;
    assign m_axi.awsize  = 3'd2;
    assign m_axi.awburst = 2'b01;
    assign m_axi.awcache = 4'b0010;
    assign m_axi.awvalid = awvalid_reg;
    assign m_axi.wstrb   = 4'hF;
    assign m_axi.wlast   = wlast_reg;
    assign m_axi.wvalid  = wvalid_reg;
    assign m_axi.bready  = bready_reg;
    assign BUSY          = busy_reg;
    assign DONE          = done_reg;
endmodule
